// File: rtl/binary_mul_5_1_uni_core_if.sv
// ---------------------------------------------------------------------------
// binary_mul_5_1_uni_core_if
//
// Purpose: groups the operand/product signals of binary_mul_5_1_uni_core so
// that a producer and the multiplier core connect through one bundle.
//
// Signals:
//   en     pipeline advance enable (1 = advance, 0 = hold every stage)
//   A      5-bit unsigned multiplicand
//   B      5-bit unsigned multiplier
//   P      10-bit unsigned registered product A*B
//   valid  (only with BINARY_MUL_5_1_UNI_VALID_EN) P belongs to post-reset data
//
// Modports:
//   master  drives en/A/B, observes P (and valid)
//   slave   the multiplier core: receives en/A/B, drives P (and valid)
//
// Configuration macro: BINARY_MUL_5_1_UNI_VALID_EN adds the valid signal.
// ---------------------------------------------------------------------------
interface binary_mul_5_1_uni_core_if;
  logic       en;
  logic [4:0] A;
  logic [4:0] B;
  logic [9:0] P;
`ifdef BINARY_MUL_5_1_UNI_VALID_EN
  logic       valid;

  modport master (output en, output A, output B, input P, input valid);
  modport slave  (input en, input A, input B, output P, output valid);
`else
  modport master (output en, output A, output B, input P);
  modport slave  (input en, input A, input B, output P);
`endif
endinterface

// File: rtl/binary_mul_5_1_uni_core.sv
// ---------------------------------------------------------------------------
// binary_mul_5_1_uni_core
//
// Purpose: unsigned 5x5 -> 10-bit multiplier, radix-2, one partial product per
// stage, fixed 6-stage register pipeline with a global stall.
//   Stage 0     : input register for A/B.
//   Stage k=1..5: acc_k = acc_(k-1) + ((A & {5{B[k-1]}}) << (k-1)),
//                 with acc_0 = 0; operands ride along to the next stage.
//   P           : the stage-5 accumulator register.
// Latency is 6 enabled edges; one new operand pair per enabled edge.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous reset, ACTIVE-HIGH despite the name; beats en
//   bus    binary_mul_5_1_uni_core_if.slave (en, A, B, P [, valid])
//
// Configuration macro: BINARY_MUL_5_1_UNI_VALID_EN adds a 6-deep valid shift
// register whose output marks P as derived from post-reset operands.
// ---------------------------------------------------------------------------
module binary_mul_5_1_uni_core (
  input  logic                          clk,
  input  logic                          rst_n,
  binary_mul_5_1_uni_core_if.slave      bus
);

  // Operand copies: index 0 is the input register, index k is carried by
  // stage k. Stage 5 consumes operands from stage 4 and carries none further.
  logic [4:0] a_q [0:4];
  logic [4:0] b_q [0:4];
  logic [4:0] a_d [0:4];
  logic [4:0] b_d [0:4];

  // Accumulators of stages 1..5; acc_q[5] is the product.
  logic [9:0] acc_q [1:5];
  logic [9:0] acc_d [1:5];

  // Partial product for stage k, taken from stage k-1's operand copies.
  function automatic logic [9:0] partial (input logic [4:0] a,
                                          input logic       b_bit,
                                          input int         shift);
    logic [9:0] pp;
    pp = {5'd0, a & {5{b_bit}}};
    return pp << shift;
  endfunction

  // NOTE: every output of an always_comb gets a value before any branch, so no
  // path leaves it unassigned and no latch can be inferred.
  always_comb begin
    a_d[0] = bus.A;
    b_d[0] = bus.B;
    for (int k = 1; k <= 4; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end

    // Stage 1 starts from zero, so it has no upstream accumulator.
    acc_d[1] = partial(a_q[0], b_q[0][0], 0);
    for (int k = 2; k <= 5; k++) begin
      acc_d[k] = acc_q[k-1] + partial(a_q[k-1], b_q[k-1][k-1], k - 1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its upstream neighbour's pre-edge value; blocking here would collapse the
  // pipeline into a single cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      // NOTE: every pipeline register is reset (not just a valid flag) because
      // P must read 0 until the first post-reset pair arrives, and zeroed
      // operands multiply to 0 as they drain.
      for (int k = 0; k <= 4; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= 5; k++) begin
        acc_q[k] <= '0;
      end
    end else if (bus.en) begin
      for (int k = 0; k <= 4; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
      for (int k = 1; k <= 5; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign bus.P = acc_q[5];

`ifdef BINARY_MUL_5_1_UNI_VALID_EN
  // One bit per stage; a 1 entering at stage 0 reaches bit 5 together with
  // its operands' product.
  logic [5:0] vld_q;
  logic [5:0] vld_d;

  always_comb begin
    vld_d = {vld_q[4:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_q <= '0;
    end else if (bus.en) begin
      vld_q <= vld_d;
    end
  end

  assign bus.valid = vld_q[5];
`endif

endmodule

// File: tb/tb_binary_mul_5_1_uni_core.sv
// ---------------------------------------------------------------------------
// tb_binary_mul_5_1_uni_core
//
// Directed self-checking bench for binary_mul_5_1_uni_core. Inputs change 1
// time unit after a rising edge; outputs are sampled at the same point, well
// away from the next active edge.
// ---------------------------------------------------------------------------
module tb_binary_mul_5_1_uni_core;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  binary_mul_5_1_uni_core_if bus ();

  binary_mul_5_1_uni_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [4:0] a, input logic [4:0] b);
    bus.en = en;
    bus.A  = a;
    bus.B  = b;
  endtask

  // Feed zeros long enough that P is 0 again.
  task automatic flush();
    drive(1'b1, 5'd0, 5'd0);
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b1, 5'd31, 5'd31);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (bus.P !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_edge%0d: P=%0d expected 0", i, bus.P);
      end
    end
    rst_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if (i < 6 && bus.P !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_drain%0d: P=%0d expected 0", i, bus.P);
      end else if (i == 6 && bus.P !== 10'd961) begin
        n_bad++;
        $display("FAIL reset_first: P=%0d expected 961", bus.P);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [9:0] exp;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        drive(1'b1, 5'(a), 5'(b));
        repeat (6) step();
        exp = 10'(a * b);
        n_cmp++;
        if (bus.P !== exp) begin
          n_bad++;
          $display("FAIL mul_%0dx%0d: P=%0d expected %0d", a, b, bus.P, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] va [0:3];
    logic [4:0] vb [0:3];
    logic [9:0] ve [0:3];
    va = '{5'd3, 5'd31, 5'd7, 5'd12};
    vb = '{5'd5, 5'd31, 5'd0, 5'd10};
    ve = '{10'd15, 10'd961, 10'd0, 10'd120};
    flush();
    for (int i = 0; i < 9; i++) begin
      if (i < 4) drive(1'b1, va[i], vb[i]);
      else       drive(1'b1, 5'd0, 5'd0);
      step();
      if (i >= 5) begin
        n_cmp++;
        if (bus.P !== ve[i-5]) begin
          n_bad++;
          $display("FAIL b2b_%0d: P=%0d expected %0d", i - 5, bus.P, ve[i-5]);
        end
      end
    end
  endtask

  task automatic test_stall();
    flush();
    drive(1'b1, 5'd9, 5'd9);
    step();                       // enabled edge 1
    drive(1'b1, 5'd0, 5'd0);
    repeat (2) step();            // enabled edges 2,3
    drive(1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.P !== 10'd0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: P=%0d expected 0", i, bus.P);
      end
    end
    drive(1'b1, 5'd0, 5'd0);
    for (int e = 4; e <= 6; e++) begin
      step();
      n_cmp++;
      if (e < 6 && bus.P !== 10'd0) begin
        n_bad++;
        $display("FAIL stall_early%0d: P=%0d expected 0", e, bus.P);
      end else if (e == 6 && bus.P !== 10'd81) begin
        n_bad++;
        $display("FAIL stall_result: P=%0d expected 81", bus.P);
      end
    end
  endtask

  task automatic test_reset_mid();
    flush();
    drive(1'b1, 5'd31, 5'd30);
    step();
    drive(1'b1, 5'd0, 5'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (bus.P !== 10'd0) begin
      n_bad++;
      $display("FAIL midrst_after: P=%0d expected 0", bus.P);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (bus.P !== 10'd0) begin
        n_bad++;
        $display("FAIL midrst_drain%0d: P=%0d expected 0", i, bus.P);
      end
    end
  endtask

`ifdef BINARY_MUL_5_1_UNI_VALID_EN
  task automatic test_valid();
    drive(1'b1, 5'd2, 5'd3);
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      if (e == 3) begin
        bus.en = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (bus.valid !== 1'b0) begin
          n_bad++;
          $display("FAIL valid_hold0: valid=%0b expected 0", bus.valid);
        end
        bus.en = 1'b1;
      end
      step();
      n_cmp++;
      if (bus.valid !== (e == 6)) begin
        n_bad++;
        $display("FAIL valid_edge%0d: valid=%0b expected %0b", e, bus.valid, e == 6);
      end
    end
    bus.en = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.P !== 10'd6) begin
      n_bad++;
      $display("FAIL valid_hold1: valid=%0b P=%0d expected 1 / 6", bus.valid, bus.P);
    end
    bus.en = 1'b1;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    drive(1'b1, 5'd0, 5'd0);
    test_reset();
    test_exhaustive();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef BINARY_MUL_5_1_UNI_VALID_EN
    test_valid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
